matmul_sequencer: RTL

- Controller that sequences one DIM x DIM matrix multiply through the systolic array.
- Captures operand matrices A and B on a start handshake and clears the array accumulators.
- Steps a shared feed index that selects row i of A and column i of B for DIM cycles, then drives zero vectors while the array drains.
- Raises result_valid until the consumer accepts. Sits between the operand source and the array's edge inputs.

---
 rtl/matmul_pkg.sv | 33 +++
 rtl/matmul_sequencer_if.sv | 46 ++++
 rtl/matmul_sequencer_operand_slice.sv | 45 ++++
 rtl/matmul_sequencer.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : matmul_pkg
//  Description : Shared types and constants for the matmul sequencer:
//                FSM state encoding, default array geometry, element type
//                and the feed-index width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package matmul_pkg;

    // Default array geometry; instances may override via module parameters.
    localparam int DIM_DEFAULT   = 4;
    localparam int WIDTH_DEFAULT = 8;

    // Feed index must also be able to hold DIM (the "zero vector" slot).
    function automatic int idx_w(input int dim);
        return $clog2(dim + 1);
    endfunction

    localparam int IDX_W = idx_w(DIM_DEFAULT);

    typedef logic [WIDTH_DEFAULT-1:0] elem_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } seq_state_t;

endpackage : matmul_pkg
`default_nettype wire

// File: rtl/matmul_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : matmul_sequencer_if
//  Description : Handshake / data bundle between the operand source, the
//                systolic array edge and the matmul sequencer.
//                master = source/array/consumer side, slave = sequencer.
//  Signals     : start/start_ready, a_in/b_in (DIM*DIM*WIDTH), stall, abort,
//                a_vec/b_vec (DIM*WIDTH), feed_index, feed_valid,
//                array_clear, result_valid/result_ready, busy
//  Revision    : 1.0  initial release
// ============================================================================
interface matmul_sequencer_if #(
    parameter int DIM   = 4,
    parameter int WIDTH = 8
);
    localparam int c_IDX_W = $clog2(DIM + 1);

    logic                       start;
    logic                       start_ready;
    logic [DIM*DIM*WIDTH-1:0]   a_in;
    logic [DIM*DIM*WIDTH-1:0]   b_in;
    logic                       stall;
    logic                       abort;
    logic [DIM*WIDTH-1:0]       a_vec;
    logic [DIM*WIDTH-1:0]       b_vec;
    logic [c_IDX_W-1:0]         feed_index;
    logic                       feed_valid;
    logic                       array_clear;
    logic                       result_valid;
    logic                       result_ready;
    logic                       busy;

    modport master (
        output start, a_in, b_in, stall, abort, result_ready,
        input  start_ready, a_vec, b_vec, feed_index, feed_valid,
               array_clear, result_valid, busy
    );

    modport slave (
        input  start, a_in, b_in, stall, abort, result_ready,
        output start_ready, a_vec, b_vec, feed_index, feed_valid,
               array_clear, result_valid, busy
    );

endinterface : matmul_sequencer_if
`default_nettype wire

// File: rtl/matmul_sequencer_operand_slice.sv
`default_nettype none
// ============================================================================
//  Module      : operand_slice
//  Description : Combinational slice select from a flattened DIM x DIM
//                matrix laid out [row][col][WIDTH] (element (0,0) at LSB).
//                ROW!=0 returns row i_index, ROW==0 returns column i_index.
//                Any index >= DIM yields an all-zero vector.
//  Ports       : i_mat   [DIM*DIM*WIDTH] registered matrix
//                i_index [IDX_W]         slice index
//                o_vec   [DIM*WIDTH]     selected slice, element k at k*WIDTH
//  Revision    : 1.0  initial release
// ============================================================================
module operand_slice #(
    parameter int DIM   = 4,
    parameter int WIDTH = 8,
    parameter int ROW   = 1,
    parameter int IDX_W = 3
) (
    input  wire logic [DIM*DIM*WIDTH-1:0] i_mat,
    input  wire logic [IDX_W-1:0]         i_index,
    output logic      [DIM*WIDTH-1:0]     o_vec
);

    logic [DIM*WIDTH-1:0] w_vec;

    // Compare against every legal index rather than using i_index as a
    // variable part-select base: index DIM falls through to the zero default.
    always_comb begin
        w_vec = '0;
        for (int s = 0; s < DIM; s++) begin
            if (i_index == IDX_W'(s)) begin
                for (int k = 0; k < DIM; k++) begin
                    if (ROW != 0)
                        w_vec[k*WIDTH +: WIDTH] = i_mat[(s*DIM + k)*WIDTH +: WIDTH];
                    else
                        w_vec[k*WIDTH +: WIDTH] = i_mat[(k*DIM + s)*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign o_vec = w_vec;

endmodule : operand_slice
`default_nettype wire

// File: rtl/matmul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : matmul_sequencer
//  Description : Sequences one DIM x DIM matrix multiply through a systolic
//                array: latches A/B on start, pulses an accumulator clear,
//                feeds row i of A / column i of B for DIM slices, feeds zero
//                vectors for DRAIN_CYCLES while the array drains, then holds
//                result_valid until the consumer accepts.
//  Ports       : clk      clock
//                reset_n  asynchronous active-low reset
//                bus      matmul_sequencer_if.slave (handshakes, operands,
//                         feed vectors, status)
//  Revision    : 1.0  initial release
// ============================================================================
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int DIM          = 4,
    parameter int WIDTH        = 8,
    parameter int DRAIN_CYCLES = 7
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    matmul_sequencer_if.slave bus
);

    localparam int c_IDX_W = idx_w(DIM);
    localparam int c_DRN_W = $clog2(DRAIN_CYCLES + 1);
    localparam int c_MAT_W = DIM * DIM * WIDTH;

    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DIM - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_END  = c_IDX_W'(DIM);
    localparam logic [c_DRN_W-1:0] c_DRN_LAST = c_DRN_W'(DRAIN_CYCLES - 1);

    seq_state_t          r_state;
    logic [c_IDX_W-1:0]  r_idx;
    logic [c_DRN_W-1:0]  r_drain;
    logic [c_MAT_W-1:0]  r_a;
    logic [c_MAT_W-1:0]  r_b;

    logic [DIM*WIDTH-1:0] w_a_vec;
    logic [DIM*WIDTH-1:0] w_b_vec;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_drain <= '0;
            r_a     <= '0;
            r_b     <= '0;
        end else if (bus.abort && (r_state != IDLE)) begin
            // Operands are left in place; they are stale until the next accept.
            r_state <= IDLE;
            r_idx   <= '0;
            r_drain <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.a_in;
                        r_b     <= bus.b_in;
                        r_state <= CLEAR;
                    end
                end
                CLEAR: begin
                    r_idx   <= '0;
                    r_state <= FEED;
                end
                FEED: begin
                    if (!bus.stall) begin
                        if (r_idx == c_IDX_LAST) begin
                            r_idx   <= c_IDX_END;
                            r_drain <= '0;
                            r_state <= FLUSH;
                        end else begin
                            r_idx <= r_idx + c_IDX_W'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (!bus.stall) begin
                        if (r_drain == c_DRN_LAST) begin
                            r_drain <= '0;
                            r_state <= DONE;
                        end else begin
                            r_drain <= r_drain + c_DRN_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (bus.result_ready) begin
                        r_idx   <= '0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_idx   <= '0;
                    r_drain <= '0;
                end
            endcase
        end
    end

    // Row i of A and column i of B; index DIM (FLUSH/DONE) gives zero vectors.
    operand_slice #(
        .DIM   (DIM),
        .WIDTH (WIDTH),
        .ROW   (1),
        .IDX_W (c_IDX_W)
    ) u_a_slice (
        .i_mat   (r_a),
        .i_index (r_idx),
        .o_vec   (w_a_vec)
    );

    operand_slice #(
        .DIM   (DIM),
        .WIDTH (WIDTH),
        .ROW   (0),
        .IDX_W (c_IDX_W)
    ) u_b_slice (
        .i_mat   (r_b),
        .i_index (r_idx),
        .o_vec   (w_b_vec)
    );

    // Status outputs decode the registered state only; feed_valid alone
    // follows stall in the same cycle so the array never sees a held slice twice.
    assign bus.start_ready  = (r_state == IDLE);
    assign bus.busy         = (r_state != IDLE);
    assign bus.array_clear  = (r_state == CLEAR);
    assign bus.result_valid = (r_state == DONE);
    assign bus.feed_valid   = (r_state == FEED) && !bus.stall;
    assign bus.feed_index   = r_idx;
    assign bus.a_vec        = w_a_vec;
    assign bus.b_vec        = w_b_vec;

endmodule : matmul_sequencer
`default_nettype wire
